// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller feeding CP0 HWInt[7:2], with a claim/complete handshake.
// Optional feature macro INTC_SYNC_EN adds a 2-flop synchroniser ahead of the sampling stage.
module int_ctrl #(
  parameter int         NSRC     = 6,
  parameter logic [5:0] MASK_RST = 6'h3F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hw_int,
  output logic            busy
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  state_t          state_q;
  logic [NSRC-1:0] irq_src_s;
  logic [NSRC-1:0] s_irq_q, p_irq_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mode_q;
  logic [2:0]      k_q;
  logic            busy_q;
  logic [NSRC-1:0] allow_s, hw_s, rise_s, clr_s, w1c_s, claim_clr_s;
  logic [2:0]      id_s;
  logic            claim_s, complete_s;
  logic            unused_s;

  function automatic logic [2:0] first_id(input logic [5:0] v);
    if (v[0])      first_id = 3'd1;
    else if (v[1]) first_id = 3'd2;
    else if (v[2]) first_id = 3'd3;
    else if (v[3]) first_id = 3'd4;
    else if (v[4]) first_id = 3'd5;
    else if (v[5]) first_id = 3'd6;
    else           first_id = 3'd0;
  endfunction

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  // Two-flop metastability synchroniser for asynchronous device lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_src_s = sync2_q;
`else
  assign irq_src_s = irq_in;
`endif

  assign unused_s = ^wdata[31:6];

  // Priority gate: while servicing k only strictly higher-priority sources get through.
  always_comb begin
    if (state_q == ST_SERVICE) allow_s = (6'd1 << k_q) - 6'd1;
    else                       allow_s = 6'h3F;
  end

  assign rise_s      = s_irq_q & ~p_irq_q;
  assign hw_s        = pend_q & mask_q & allow_s;
  assign id_s        = first_id(hw_s);
  assign claim_s     = re & sel & (addr == 2'd3) & (id_s != 3'd0) & (state_q == ST_IDLE);
  assign complete_s  = we & sel & (addr == 2'd3) & (wdata[2:0] == (k_q + 3'd1))
                       & (state_q == ST_SERVICE);
  assign w1c_s       = (we && sel && (addr == 2'd0)) ? wdata[5:0] : 6'd0;
  assign claim_clr_s = claim_s ? (6'd1 << (id_s - 3'd1)) : 6'd0;
  assign clr_s       = w1c_s | claim_clr_s;

  // Edge bits: rise sets (and beats any clear); level bits simply track the sampled line.
  assign pend_d = (mode_q & (rise_s | (pend_q & ~clr_s))) | (~mode_q & s_irq_q);

  // Sampling, register file and claim/complete state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_irq_q <= 6'd0;
      p_irq_q <= 6'd0;
      pend_q  <= 6'd0;
      mask_q  <= MASK_RST;
      mode_q  <= 6'd0;
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      s_irq_q <= irq_src_s;
      p_irq_q <= s_irq_q;
      pend_q  <= pend_d;
      if (we && sel && (addr == 2'd1)) mask_q <= wdata[5:0];
      if (we && sel && (addr == 2'd2)) mode_q <= wdata[5:0];
      case (state_q)
        ST_IDLE: begin
          if (claim_s) begin
            state_q <= ST_SERVICE;
            k_q     <= id_s - 3'd1;
            busy_q  <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (complete_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read mux; unused upper bits are forced to zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = {26'd0, pend_q};
      2'd1:    rdata = {26'd0, mask_q};
      2'd2:    rdata = {26'd0, mode_q};
      2'd3:    rdata = {29'd0, id_s};
      default: rdata = 32'd0;
    endcase
  end

  assign hw_int = hw_s;
  assign busy   = busy_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expected values queued on stimulus, popped and checked on observation.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];
  logic [31:0] d;

  int_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .sel    (sel),
    .addr   (addr),
    .we     (we),
    .re     (re),
    .wdata  (wdata),
    .rdata  (rdata),
    .hw_int (hw_int),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk);
    v = rdata;
    cyc(1);
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    sel = 1'b1; we = 1'b1; addr = a; wdata = v;
    cyc(1);
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (val_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required queued entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = 6'd0; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = 2'd0; wdata = 32'd0;
    cyc(3);
    reset = 1'b0;

    // Reset state
    push("rst_pend", 32'h0);  rd(2'd0, d); pop_check(d);
    push("rst_mask", 32'h3F); rd(2'd1, d); pop_check(d);
    push("rst_mode", 32'h0);  rd(2'd2, d); pop_check(d);
    push("rst_claim", 32'h0); rd(2'd3, d); pop_check(d);
    push("rst_hw_int", 32'h0); pop_check({26'd0, hw_int});
    push("rst_busy", 32'h0);   pop_check({31'd0, busy});

    // Level source 2: latency, claim, drop, complete
    irq_in = 6'b000100;
    cyc(LAT - 1);
    push("lvl_hw_early", 32'h0); pop_check({26'd0, hw_int});
    cyc(1);
    push("lvl_hw", 32'h04); pop_check({26'd0, hw_int});
    push("lvl_claim", 32'h3); rd(2'd3, d); pop_check(d);
    push("lvl_busy", 32'h1); pop_check({31'd0, busy});
    push("lvl_hw_blocked", 32'h0); pop_check({26'd0, hw_int});
    push("lvl_pend_held", 32'h04); rd(2'd0, d); pop_check(d);
    irq_in = 6'd0;
    cyc(LAT);
    push("lvl_pend_drop", 32'h0); rd(2'd0, d); pop_check(d);
    wr(2'd3, 32'd3);
    push("lvl_complete_busy", 32'h0); pop_check({31'd0, busy});

    // Edge mode: pulse latched, set beats W1C, plain W1C clears
    wr(2'd2, 32'h3F);
    irq_in = 6'b010000;
    cyc(1);
    irq_in = 6'd0;
    cyc(LAT + 2);
    push("edge_pend_held", 32'h10); rd(2'd0, d); pop_check(d);
    push("edge_hw", 32'h10); pop_check({26'd0, hw_int});
    irq_in = 6'b010000;
    cyc(LAT - 1);
    irq_in = 6'd0;
    wr(2'd0, 32'h10);
    push("edge_set_wins", 32'h10); rd(2'd0, d); pop_check(d);
    wr(2'd0, 32'h10);
    push("edge_w1c", 32'h0); rd(2'd0, d); pop_check(d);

    // Edge sources 1 and 3: claim, priority block, bad/good complete
    irq_in = 6'b001010;
    cyc(LAT);
    irq_in = 6'd0;
    cyc(2);
    push("pri_hw", 32'h0A); pop_check({26'd0, hw_int});
    push("pri_claim", 32'h2); rd(2'd3, d); pop_check(d);
    push("pri_pend", 32'h08); rd(2'd0, d); pop_check(d);
    push("pri_hw_blocked", 32'h0); pop_check({26'd0, hw_int});
    push("pri_claim_in_svc", 32'h0); rd(2'd3, d); pop_check(d);
    wr(2'd3, 32'd4);
    push("pri_bad_complete", 32'h1); pop_check({31'd0, busy});
    wr(2'd3, 32'd2);
    push("pri_complete_busy", 32'h0); pop_check({31'd0, busy});
    push("pri_hw_after", 32'h08); pop_check({26'd0, hw_int});
    wr(2'd0, 32'h08);
    wr(2'd2, 32'h0);

    // Mask gating in level mode
    wr(2'd1, 32'h3E);
    irq_in = 6'b000001;
    cyc(LAT + 1);
    push("mask_hw", 32'h0); pop_check({26'd0, hw_int});
    push("mask_claim", 32'h0); rd(2'd3, d); pop_check(d);
    push("mask_busy", 32'h0); pop_check({31'd0, busy});
    wr(2'd1, 32'h3F);
    push("unmask_hw", 32'h01); pop_check({26'd0, hw_int});

    // Reset in the middle of servicing source 3
    irq_in = 6'b001000;
    cyc(LAT + 1);
    push("svc3_claim", 32'h4); rd(2'd3, d); pop_check(d);
    push("svc3_busy", 32'h1); pop_check({31'd0, busy});
    reset = 1'b1; irq_in = 6'd0;
    cyc(1);
    reset = 1'b0;
    push("mid_rst_busy", 32'h0); pop_check({31'd0, busy});
    push("mid_rst_hw", 32'h0); pop_check({26'd0, hw_int});
    push("mid_rst_pend", 32'h0); rd(2'd0, d); pop_check(d);
    push("mid_rst_mask", 32'h3F); rd(2'd1, d); pop_check(d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Programmable interrupt controller between the external device IRQ lines and the CP0 HWInt[7:2] inputs.
- Latches device requests as level or edge events.
- Applies a software mask and fixed priority.
- Provides a claim/complete handshake so the exception handler can identify and retire one source at a time.
- Sits on the system bridge as a memory-mapped device with a 4-word register window.

Parameters:
NSRC, 6, number of interrupt sources; fixed at 6 to match HWInt[7:2]. Other values are unsupported.
MASK_RST, 6'h3F, reset value of the MASK register.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
irq_in  input  6  raw device interrupt lines; bit 0 is highest priority
sel  input  1  bridge decode: this device is addressed
addr  input  2  word offset (byte address bits [3:2])
we  input  1  write strobe, qualified by sel
re  input  1  read strobe, qualified by sel; one-cycle pulse per load
wdata  input  32  write data
rdata  output  32  read data, combinational from addr
hw_int  output  6  to CP0 HWInt[7:2]; bit i drives HWInt[i+2]
busy  output  1  high while a claimed source is in service

Behaviour:
Input sampling:
- irq_in is registered once into s_irq.
- A second register, p_irq, holds the previous s_irq.
- rise = s_irq & ~p_irq.

Register map (offset: name, access, reset):
- 0 PEND, R/W1C, 0. Bits [5:0] valid, upper bits read 0.
- 1 MASK, R/W, MASK_RST.
- 2 MODE, R/W, 0. 1 = edge, 0 = level.
- 3 CLAIM, R = id, W = complete. id = index+1 of the lowest-index bit of (PEND & MASK & allow), 0 if none.

PEND update, per bit:
- Level mode: PEND[i] <= s_irq[i] every cycle. W1C and claim have no effect.
- Edge mode: set on rise[i]. Cleared by a W1C write of 1, or by a claim of that source.
- Set and clear in the same cycle: set wins.
- Changing MODE does not itself clear PEND.

Priority gating (allow):
- IDLE: allow = 6'h3F.
- SERVICE with claimed index k: allow = bits with index < k (strictly higher priority only). This permits nesting one level deep.

Output:
- hw_int = PEND & MASK & allow, combinational from registers.
- Latency: irq_in edge at clock n produces hw_int high after clock n+2 (two flops).

State machine:
- IDLE -> SERVICE when re && sel && addr==3 && id!=0. Latch k = id-1; busy=1. Edge-mode bit k is cleared that same edge.
- A CLAIM read returning 0 causes no state change.
- SERVICE -> IDLE on we && sel && addr==3 && wdata[2:0]==k+1. busy=0.
- A complete write with any other value is ignored; state is held.
- A CLAIM read while in SERVICE returns the id of a higher-priority source but does not change k (no stacking). The handler must complete the original k.

Bus behaviour:
- Writes to CLAIM never alter PEND or MASK.
- Read and write in the same cycle to different offsets are both honoured.
- rdata bits above 5 (above 2 for CLAIM) are 0.

Reset:
- Reset is synchronous and overrides all other activity, including reset asserted mid-service.
- Reset values: s_irq, p_irq, PEND, MODE = 0; MASK = MASK_RST; state = IDLE; k = 0; busy = 0; hw_int = 0.

Optional Feature:
INTC_SYNC_EN
- Defined: irq_in passes through an additional 2-flop metastability synchroniser before s_irq. Latency becomes 4 cycles; all other behaviour is unchanged.
- Undefined: single sampling stage as above (for synchronous on-chip devices such as the timer).

Test Plan:
1. After reset, read all 4 offsets -> PEND=0, MASK=0x3F, MODE=0, CLAIM=0; hw_int=0; busy=0.
2. Level mode, irq_in=6'b000100 at cycle 10 -> hw_int=6'b000100 after cycle 12. CLAIM read -> 3, busy=1. Drop irq_in -> PEND[2]=0 two cycles later. Write CLAIM=3 -> busy=0.
3. MODE=0x3F, pulse irq_in[4] for 1 cycle -> PEND=0x10 and held. W1C write PEND=0x10 in the same cycle as a new rise[4] -> PEND stays 0x10 (set wins).
4. Edge sources 1 and 3 pending -> CLAIM read -> 2, PEND=0x08, hw_int=0 (index 3 > 1 is blocked). Write CLAIM=4 -> ignored, busy=1. Write CLAIM=2 -> IDLE, hw_int=0x08.
5. MASK=0x3E with irq_in[0] level high -> hw_int=0, CLAIM=0. Set MASK=0x3F -> hw_int=0x01 the next cycle.
6. In SERVICE k=3, assert reset for 1 cycle -> busy=0, PEND=0, MASK=0x3F, hw_int=0 on the following cycle. With INTC_SYNC_EN, repeat scenario 2 -> hw_int after cycle 14.
